// File: rtl/code_event_queue_pkg.sv
// Shared types for the code event queue: encoder code width and code count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package code_event_pkg;
  localparam int CODE_W    = 2;
  localparam int NUM_CODES = 4;

  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/code_event_queue_if.sv
// Bundle of encoder input, event output handshake and status for code_event_queue.
// Latency: n/a (wiring only).
// Backpressure: i_evt_ready from the consumer; o_evt_valid never depends on it.
// Ports: i_code/i_valid (encoder), o_evt_code/o_evt_valid/i_evt_ready (event port),
//        o_hit_count (packed per-code counters, code 0 in the low slice), o_full, o_overflow.
interface code_event_queue_if
  import code_event_pkg::*;
#(
  parameter int CNT_W = 8
) ();
  code_t                      i_code;
  logic                       i_valid;
  code_t                      o_evt_code;
  logic                       o_evt_valid;
  logic                       i_evt_ready;
  logic [NUM_CODES*CNT_W-1:0] o_hit_count;
  logic                       o_full;
  logic                       o_overflow;

  // master drives the encoder side and the consumer ready; slave is the queue
  modport master (
    output i_code, i_valid, i_evt_ready,
    input  o_evt_code, o_evt_valid, o_hit_count, o_full, o_overflow
  );

  modport slave (
    input  i_code, i_valid, i_evt_ready,
    output o_evt_code, o_evt_valid, o_hit_count, o_full, o_overflow
  );
endinterface

// File: rtl/code_event_queue_fifo.sv
// Generic synchronous show-ahead FIFO with extra-MSB pointers.
// Latency: a push is visible at o_data one edge later; no push-to-pop bypass.
// Backpressure: push while full succeeds only with a same-cycle pop; pop while empty is ignored.
// Ports: i_clk, i_rst (sync, active high), i_push/i_data, i_pop, o_data (head), o_empty, o_full.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = i_pop && !o_empty;
  // When full, a concurrent pop frees the slot the write lands in.
  assign do_push = i_push && (!o_full || do_pop);

  // Head reads as zero while empty so the output is defined out of reset.
  assign o_data = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end
endmodule

// File: rtl/code_event_queue.sv
// Detects encoder code events (valid rise or code change while valid), queues them, counts hits.
// Latency: event sampled at edge N is at the queue head in cycle N+1 when the queue was empty.
// Backpressure: i_evt_ready pops the head; events arriving while full with no pop are dropped
//               and set the sticky overflow flag (counters still count them).
// Ports: i_clk, i_rst (sync, active high), bus (code_event_queue_if.slave).
module code_event_queue
  import code_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  code_event_queue_if.slave bus
);
  code_t                      prev_code;
  logic                       prev_valid;
  logic                       evt;
  logic                       pop;
  logic                       fifo_empty;
  logic                       fifo_full;
  code_t                      fifo_data;
  logic                       overflow;
  logic [CNT_W-1:0]           hit_cnt [NUM_CODES];
  logic [NUM_CODES*CNT_W-1:0] hit_flat;

  // The code is only meaningful while valid, so a change is judged against
  // the previous sample only when that sample was also valid.
  assign evt = bus.i_valid && (!prev_valid || (bus.i_code != prev_code));
  assign pop = !fifo_empty && bus.i_evt_ready;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (evt),
    .i_data  (bus.i_code),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_code  <= '0;
      prev_valid <= 1'b0;
      overflow   <= 1'b0;
      for (int k = 0; k < NUM_CODES; k++) begin
        hit_cnt[k] <= '0;
      end
    end else begin
      prev_code  <= bus.i_code;
      prev_valid <= bus.i_valid;
      if (evt && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      if (evt && (hit_cnt[bus.i_code] != '1)) begin
        hit_cnt[bus.i_code] <= hit_cnt[bus.i_code] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hit_flat = '0;
    for (int k = 0; k < NUM_CODES; k++) begin
      hit_flat[k*CNT_W +: CNT_W] = hit_cnt[k];
    end
  end

  assign bus.o_evt_code  = fifo_data;
  assign bus.o_evt_valid = !fifo_empty;
  assign bus.o_full      = fifo_full;
  assign bus.o_overflow  = overflow;
  assign bus.o_hit_count = hit_flat;
endmodule

// File: tb/tb_code_event_queue.sv
// Bench for code_event_queue: vector table, hand sequences and randomized run vs a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_code_event_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] code;
  logic       valid;
  logic       ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  code_event_queue_if #(.CNT_W(8)) if8 ();
  code_event_queue_if #(.CNT_W(2)) if2 ();

  assign if8.i_code      = code;
  assign if8.i_valid     = valid;
  assign if8.i_evt_ready = ready;
  assign if2.i_code      = code;
  assign if2.i_valid     = valid;
  assign if2.i_evt_ready = ready;

  code_event_queue #(.DEPTH(DEPTH), .CNT_W(8)) dut8 (.i_clk(clk), .i_rst(rst), .bus(if8.slave));
  code_event_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));

  // Reference model: an event list plus per-code tallies.
  int q[$];
  int cnt8 [4];
  int cnt2 [4];
  bit m_ovf;
  bit m_pv;
  int m_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input int c, input bit v, input bit rd);
    bit e;
    if (r) begin
      q.delete();
      for (int k = 0; k < 4; k++) begin
        cnt8[k] = 0;
        cnt2[k] = 0;
      end
      m_ovf = 0;
      m_pv  = 0;
      m_pc  = 0;
    end else begin
      e = v && (!m_pv || c != m_pc);
      if (rd && q.size() > 0) void'(q.pop_front());
      if (e) begin
        if (q.size() < DEPTH) q.push_back(c);
        else m_ovf = 1;
        if (cnt8[c] < 255) cnt8[c]++;
        if (cnt2[c] < 3) cnt2[c]++;
      end
      m_pv = v;
      m_pc = c;
    end
  endtask

  task automatic compare_model();
    logic [31:0] e8;
    logic [7:0]  e2;
    for (int k = 0; k < 4; k++) begin
      e8[k*8 +: 8] = 8'(cnt8[k]);
      e2[k*2 +: 2] = 2'(cnt2[k]);
    end
    check("m_evt_valid", 64'(if8.o_evt_valid), 64'(q.size() != 0));
    check("m_evt_valid_w2", 64'(if2.o_evt_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("m_evt_code", 64'(if8.o_evt_code), 64'(q[0]));
      check("m_evt_code_w2", 64'(if2.o_evt_code), 64'(q[0]));
    end
    check("m_full", 64'(if8.o_full), 64'(q.size() == DEPTH));
    check("m_overflow", 64'(if8.o_overflow), 64'(m_ovf));
    check("m_overflow_w2", 64'(if2.o_overflow), 64'(m_ovf));
    check("m_hit8", 64'(if8.o_hit_count), 64'(e8));
    check("m_hit2", 64'(if2.o_hit_count), 64'(e2));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
  task automatic apply(input bit r, input bit [1:0] c, input bit v, input bit rd);
    rst   = r;
    code  = c;
    valid = v;
    ready = rd;
    @(posedge clk);
    model_step(r, int'(c), v, rd);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    bit        rst;
    bit [1:0]  code;
    bit        valid;
    bit        ready;
    bit        ev;
    bit [1:0]  ec;
    bit        full;
    bit        ovf;
    bit [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit [1:0] c, input bit v, input bit rd,
                              input bit ev, input bit [1:0] ec, input bit f, input bit o,
                              input bit [31:0] cn);
    vec_t x;
    x.rst = r; x.code = c; x.valid = v; x.ready = rd;
    x.ev = ev; x.ec = ec; x.full = f; x.ovf = o; x.cnt = cn;
    vecs.push_back(x);
  endfunction

  initial begin
    // Steady code 2 with no consumer: one entry, then drain.
    add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) add(0, 2, 1, 0, 1, 2, 0, 0, 32'h00010000);
    add(0, 0, 0, 1, 0, 0, 0, 0, 32'h00010000);
    // Back-to-back changes 0,1,3,1 with ready: each appears one cycle later.
    add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 1, 1, 1, 0, 0, 0, 32'h00000001);
    add(0, 1, 1, 1, 1, 1, 0, 0, 32'h00000101);
    add(0, 3, 1, 1, 1, 3, 0, 0, 32'h01000101);
    add(0, 1, 1, 1, 1, 1, 0, 0, 32'h01000201);
    add(0, 1, 0, 1, 0, 0, 0, 0, 32'h01000201);
    // Six events without a consumer: full after 4, overflow on the 5th, drain first 4.
    add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 32'h00000001);
    add(0, 1, 1, 0, 1, 0, 0, 0, 32'h00000101);
    add(0, 2, 1, 0, 1, 0, 0, 0, 32'h00010101);
    add(0, 3, 1, 0, 1, 0, 1, 0, 32'h01010101);
    add(0, 0, 1, 0, 1, 0, 1, 1, 32'h01010102);
    add(0, 1, 1, 0, 1, 0, 1, 1, 32'h01010202);
    add(0, 0, 0, 1, 1, 1, 0, 1, 32'h01010202);
    add(0, 0, 0, 1, 1, 2, 0, 1, 32'h01010202);
    add(0, 0, 0, 1, 1, 3, 0, 1, 32'h01010202);
    add(0, 0, 0, 1, 0, 0, 0, 1, 32'h01010202);
    // Full plus event plus pop: no overflow, stays full, new code last out.
    add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 32'h00000001);
    add(0, 1, 1, 0, 1, 0, 0, 0, 32'h00000101);
    add(0, 2, 1, 0, 1, 0, 0, 0, 32'h00010101);
    add(0, 3, 1, 0, 1, 0, 1, 0, 32'h01010101);
    add(0, 1, 1, 1, 1, 1, 1, 0, 32'h01010201);
    add(0, 0, 0, 1, 1, 2, 0, 0, 32'h01010201);
    add(0, 0, 0, 1, 1, 3, 0, 0, 32'h01010201);
    add(0, 0, 0, 1, 1, 1, 0, 0, 32'h01010201);
    add(0, 0, 0, 1, 0, 0, 0, 0, 32'h01010201);

    // Reset then idle: invalid input with any code never produces an event.
    apply(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      apply(0, 2'($urandom_range(0, 3)), 0, 1);
      check("idle_evt_valid", 64'(if8.o_evt_valid), 64'd0);
      check("idle_hits", 64'(if8.o_hit_count), 64'd0);
      check("idle_overflow", 64'(if8.o_overflow), 64'd0);
    end

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].code, vecs[i].valid, vecs[i].ready);
      check($sformatf("vec%0d_evt_valid", i), 64'(if8.o_evt_valid), 64'(vecs[i].ev));
      if (vecs[i].ev) check($sformatf("vec%0d_evt_code", i), 64'(if8.o_evt_code), 64'(vecs[i].ec));
      check($sformatf("vec%0d_full", i), 64'(if8.o_full), 64'(vecs[i].full));
      check($sformatf("vec%0d_overflow", i), 64'(if8.o_overflow), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_hits", i), 64'(if8.o_hit_count), 64'(vecs[i].cnt));
    end

    // Saturation: five code-3 events by toggling valid.
    apply(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(0, 3, 1, 1);
      apply(0, 3, 0, 1);
    end
    check("sat_w2_code3", 64'(if2.o_hit_count[7:6]), 64'd3);
    check("sat_w8_code3", 64'(if8.o_hit_count[31:24]), 64'd5);

    // Reset with entries queued, then a valid input matching the pre-reset code.
    apply(0, 1, 1, 0);
    apply(0, 2, 1, 0);
    check("preq_evt_valid", 64'(if8.o_evt_valid), 64'd1);
    apply(1, 2, 1, 0);
    check("rst_evt_valid", 64'(if8.o_evt_valid), 64'd0);
    check("rst_full", 64'(if8.o_full), 64'd0);
    check("rst_overflow", 64'(if2.o_overflow), 64'd0);
    check("rst_hits8", 64'(if8.o_hit_count), 64'd0);
    check("rst_hits2", 64'(if2.o_hit_count), 64'd0);
    apply(0, 2, 1, 0);
    check("post_rst_evt_valid", 64'(if8.o_evt_valid), 64'd1);
    check("post_rst_evt_code", 64'(if8.o_evt_code), 64'd2);
    check("post_rst_hits", 64'(if8.o_hit_count), 64'h00010000);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 199) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
